zoned_alarm_ctrl: RTL and testbench

Parametrised successor of the single-trigger home alarm FSM. It supports N sensor zones, each either instant or delayed, and timed exit, entry and siren phases. Disarming uses a keypad code entry with a wrong-code lockout. It sits between the sensor/keypad front-end and the siren/status outputs of the home-security design.

---
 rtl/zoned_alarm_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_zoned_alarm_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zoned_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// zoned_alarm_ctrl
//
// Multi-zone home alarm controller. Each sensor zone is either instant (goes
// straight to ALARM) or delayed (passes through a timed ENTRY phase first).
// Arming starts a timed EXIT phase. The siren phase (ALARM) is timed and
// re-arms when it expires. A keypad code disarms from any state. Too many
// consecutive wrong codes lock the keypad out for a fixed time.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   arm_req     arm request (acted on only in DISARMED)
//   zone_trig   per-zone sensor triggers, level-sampled
//   key_valid   key_digit is valid this cycle
//   key_digit   keypad digit
//   key_clear   discard the partially entered code (wins over key_valid)
//   state       current state: DISARMED=0 EXIT=1 ARMED=2 ENTRY=3 ALARM=4
//   armed       high in ARMED, ENTRY and ALARM
//   alarm       high in ALARM only
//   alarm_zone  sticky record of zones that triggered while armed
//   code_ok     one-cycle pulse: correct code accepted
//   code_bad    one-cycle pulse: wrong code accepted
//   locked      keypad lockout active
// -----------------------------------------------------------------------------
module zoned_alarm_ctrl #(
  parameter int                            ZONES        = 4,
  parameter logic [ZONES-1:0]              INSTANT_MASK = ZONES'(4'b0001),
  parameter int                            DIGIT_W      = 4,
  parameter int                            CODE_DIGITS  = 4,
  parameter logic [CODE_DIGITS*DIGIT_W-1:0] CODE        = (CODE_DIGITS*DIGIT_W)'(16'h1234),
  parameter int                            EXIT_CYCLES  = 16,
  parameter int                            ENTRY_CYCLES = 8,
  parameter int                            ALARM_CYCLES = 32,
  parameter int                            MAX_TRIES    = 3,
  parameter int                            LOCK_CYCLES  = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm_req,
  input  logic [ZONES-1:0]   zone_trig,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_clear,
  output logic [2:0]         state,
  output logic               armed,
  output logic               alarm,
  output logic [ZONES-1:0]   alarm_zone,
  output logic               code_ok,
  output logic               code_bad,
  output logic               locked
);

  localparam int MAX_T12 = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
  localparam int MAX_T   = (MAX_T12 > ALARM_CYCLES) ? MAX_T12 : ALARM_CYCLES;
  localparam int TW      = $clog2(MAX_T + 1);
  localparam int BW      = CODE_DIGITS * DIGIT_W;
  localparam int CW      = $clog2(CODE_DIGITS + 1);
  localparam int FW      = $clog2(MAX_TRIES + 1);
  localparam int LW      = $clog2(LOCK_CYCLES + 1);

  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] T_EXIT  = TW'(EXIT_CYCLES);
  localparam logic [TW-1:0] T_ENTRY = TW'(ENTRY_CYCLES);
  localparam logic [TW-1:0] T_ALARM = TW'(ALARM_CYCLES);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [TW-1:0]      timer_reg, timer_next;
  logic [ZONES-1:0]   alarm_zone_reg, alarm_zone_next;
  logic               armed_reg, alarm_reg;

  logic [BW-1:0]      code_buf_reg;
  logic [BW-1:0]      code_buf_shift;
  logic [CW-1:0]      digit_cnt_reg;
  logic [FW-1:0]      fail_cnt_reg;
  logic [FW-1:0]      fail_cnt_inc;
  logic [LW-1:0]      lock_timer_reg;
  logic               locked_reg, code_ok_reg, code_bad_reg;

  logic [ZONES-1:0]   inst_hit, del_hit;
  logic               key_take, last_digit, code_hit, match, timer_done;

  // Split each zone's trigger into its instant or delayed class.
  for (genvar gi = 0; gi < ZONES; gi++) begin : g_zone
    assign inst_hit[gi] = zone_trig[gi] &  INSTANT_MASK[gi];
    assign del_hit[gi]  = zone_trig[gi] & ~INSTANT_MASK[gi];
  end

  // Buffer contents after shifting in the current digit; the oldest digit
  // ends up in the most significant position, matching CODE's layout.
  if (CODE_DIGITS == 1) begin : g_shift1
    assign code_buf_shift = key_digit;
  end else begin : g_shiftn
    assign code_buf_shift = {code_buf_reg[BW-DIGIT_W-1:0], key_digit};
  end

  assign key_take     = key_valid & ~key_clear & ~locked_reg;
  assign last_digit   = (digit_cnt_reg == CW'(CODE_DIGITS - 1));
  assign code_hit     = (code_buf_shift == CODE);
  assign match        = key_take & last_digit & code_hit;
  assign fail_cnt_inc = fail_cnt_reg + FW'(1);
  assign timer_done   = (timer_reg == T_ONE);

  // ---------------------------------------------------------------------------
  // Next-state logic. A timed state entered with load X lasts X cycles: the
  // timer counts X..1 and the transition fires on the edge where it reads 1.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    alarm_zone_next = alarm_zone_reg;
    case (state_reg)
      S_DISARMED: begin
        if (arm_req) begin
          state_next      = S_EXIT;
          timer_next      = T_EXIT;
          alarm_zone_next = '0;
        end
      end
      S_EXIT: begin
        if (match) begin
          state_next = S_DISARMED;
          timer_next = '0;
        end else if (timer_done) begin
          state_next = S_ARMED;
          timer_next = '0;
        end else begin
          timer_next = timer_reg - T_ONE;
        end
      end
      S_ARMED: begin
        alarm_zone_next = alarm_zone_reg | zone_trig;
        if (match) begin
          state_next = S_DISARMED;
        end else if (|inst_hit) begin
          state_next = S_ALARM;
          timer_next = T_ALARM;
        end else if (|del_hit) begin
          state_next = S_ENTRY;
          timer_next = T_ENTRY;
        end
      end
      S_ENTRY: begin
        alarm_zone_next = alarm_zone_reg | zone_trig;
        if (match) begin
          state_next = S_DISARMED;
          timer_next = '0;
        end else if ((|inst_hit) || timer_done) begin
          state_next = S_ALARM;
          timer_next = T_ALARM;
        end else begin
          timer_next = timer_reg - T_ONE;
        end
      end
      S_ALARM: begin
        alarm_zone_next = alarm_zone_reg | zone_trig;
        if (match) begin
          state_next = S_DISARMED;
          timer_next = '0;
        end else if (timer_done) begin
          state_next = S_ARMED;
          timer_next = '0;
        end else begin
          timer_next = timer_reg - T_ONE;
        end
      end
      default: begin
        state_next = S_DISARMED;
        timer_next = '0;
      end
    endcase
  end

  // FSM registers; armed/alarm are decoded from the next state so they are
  // registered alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_DISARMED;
      timer_reg      <= '0;
      alarm_zone_reg <= '0;
      armed_reg      <= 1'b0;
      alarm_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      alarm_zone_reg <= alarm_zone_next;
      armed_reg      <= (state_next == S_ARMED) || (state_next == S_ENTRY) ||
                        (state_next == S_ALARM);
      alarm_reg      <= (state_next == S_ALARM);
    end
  end

  // Keypad: digit collection, code compare, fail counting and lockout. The
  // lockout timer runs independently of the FSM timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_buf_reg   <= '0;
      digit_cnt_reg  <= '0;
      fail_cnt_reg   <= '0;
      lock_timer_reg <= '0;
      locked_reg     <= 1'b0;
      code_ok_reg    <= 1'b0;
      code_bad_reg   <= 1'b0;
    end else begin
      code_ok_reg  <= 1'b0;
      code_bad_reg <= 1'b0;
      if (locked_reg) begin
        if (lock_timer_reg == LW'(1)) begin
          locked_reg     <= 1'b0;
          lock_timer_reg <= '0;
          fail_cnt_reg   <= '0;
          code_buf_reg   <= '0;
          digit_cnt_reg  <= '0;
        end else begin
          lock_timer_reg <= lock_timer_reg - LW'(1);
        end
      end else if (key_clear) begin
        code_buf_reg  <= '0;
        digit_cnt_reg <= '0;
      end else if (key_valid) begin
        code_buf_reg <= code_buf_shift;
        if (last_digit) begin
          digit_cnt_reg <= '0;
          if (code_hit) begin
            code_ok_reg  <= 1'b1;
            fail_cnt_reg <= '0;
          end else begin
            code_bad_reg <= 1'b1;
            fail_cnt_reg <= fail_cnt_inc;
            // Lockout starts on the same edge as the final code_bad pulse.
            if (fail_cnt_inc == FW'(MAX_TRIES)) begin
              locked_reg     <= 1'b1;
              lock_timer_reg <= LW'(LOCK_CYCLES);
            end
          end
        end else begin
          digit_cnt_reg <= digit_cnt_reg + CW'(1);
        end
      end
    end
  end

  assign state      = state_reg;
  assign armed      = armed_reg;
  assign alarm      = alarm_reg;
  assign alarm_zone = alarm_zone_reg;
  assign code_ok    = code_ok_reg;
  assign code_bad   = code_bad_reg;
  assign locked     = locked_reg;

endmodule

// File: tb/tb_zoned_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_zoned_alarm_ctrl
//
// Self-checking bench for zoned_alarm_ctrl with default parameters. Stimulus
// is applied one cycle at a time on the falling edge; the expected outputs
// after the following rising edge are pushed to a scoreboard queue and
// compared 1 time unit after that edge. Expected values are written out by
// hand from the intended behaviour.
// -----------------------------------------------------------------------------
module tb_zoned_alarm_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       armed;
    logic       alarm;
    logic [3:0] zone;
    logic       ok;
    logic       bad;
    logic       lk;
  } out_t;

  typedef struct {
    out_t  exp;
    string tag;
  } sb_t;

  typedef struct {
    logic       arm;
    logic [3:0] zone;
    logic       kv;
    logic [3:0] kd;
    logic       kc;
    out_t       exp;
    string      tag;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       arm_req;
  logic [3:0] zone_trig;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_clear;
  logic [2:0] state;
  logic       armed;
  logic       alarm;
  logic [3:0] alarm_zone;
  logic       code_ok;
  logic       code_bad;
  logic       locked;

  int   checks = 0;
  int   errors = 0;
  sb_t  sb[$];
  sb_t  cur;
  out_t dut_o;
  vec_t vecs[14];

  zoned_alarm_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .arm_req    (arm_req),
    .zone_trig  (zone_trig),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .key_clear  (key_clear),
    .state      (state),
    .armed      (armed),
    .alarm      (alarm),
    .alarm_zone (alarm_zone),
    .code_ok    (code_ok),
    .code_bad   (code_bad),
    .locked     (locked)
  );

  assign dut_o = {state, armed, alarm, alarm_zone, code_ok, code_bad, locked};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach its end, want finish");
    $fatal(1, "timeout");
  end

  // Expected output record from a state value; armed/alarm follow the state.
  function automatic out_t mk(input logic [2:0] st, input logic [3:0] z,
                              input logic ok, input logic bad, input logic lk);
    out_t o;
    o.st    = st;
    o.armed = (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
    o.alarm = (st == 3'd4);
    o.zone  = z;
    o.ok    = ok;
    o.bad   = bad;
    o.lk    = lk;
    return o;
  endfunction

  task automatic compare(input out_t act, input out_t exp, input string tag);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d armed=%b alarm=%b zone=%b ok=%b bad=%b lk=%b, want st=%0d armed=%b alarm=%b zone=%b ok=%b bad=%b lk=%b",
               tag, act.st, act.armed, act.alarm, act.zone, act.ok, act.bad, act.lk,
               exp.st, exp.armed, exp.alarm, exp.zone, exp.ok, exp.bad, exp.lk);
    end else begin
      $display("ok   %s: st=%0d zone=%b ok=%b bad=%b lk=%b",
               tag, act.st, act.zone, act.ok, act.bad, act.lk);
    end
  endtask

  // Scoreboard consumer: one expected record per rising edge that had stimulus.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      compare(dut_o, cur.exp, cur.tag);
    end
  end

  task automatic cyc(input logic a, input logic [3:0] z, input logic kv,
                     input logic [3:0] kd, input logic kc, input out_t e,
                     input string tag);
    sb_t s;
    @(negedge clk);
    arm_req   = a;
    zone_trig = z;
    key_valid = kv;
    key_digit = kd;
    key_clear = kc;
    s.exp = e;
    s.tag = tag;
    sb.push_back(s);
  endtask

  task automatic enter(input logic [15:0] c, input out_t mid, input out_t last,
                       input string tag);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 4'b0000, 1'b1, c[15-4*i -: 4], 1'b0, (i == 3) ? last : mid, tag);
  endtask

  // Arm from DISARMED; sensors are held active through EXIT and must be ignored.
  task automatic arm_seq();
    cyc(1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, mk(3'd1, 4'b0000, 0, 0, 0), "arm");
    for (int i = 0; i < 15; i++)
      cyc(1'b0, 4'b1111, 1'b0, 4'h0, 1'b0, mk(3'd1, 4'b0000, 0, 0, 0), "exit_hold");
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, mk(3'd2, 4'b0000, 0, 0, 0), "exit_done");
  endtask

  initial begin
    // Delayed-zone disarm, then key_clear handling (including clear+valid).
    vecs[0]  = '{1'b0, 4'b0010, 1'b0, 4'h0, 1'b0, mk(3'd3, 4'b0010, 0, 0, 0), "delayed_trig"};
    vecs[1]  = '{1'b0, 4'b0000, 1'b1, 4'h1, 1'b0, mk(3'd3, 4'b0010, 0, 0, 0), "entry_key1"};
    vecs[2]  = '{1'b0, 4'b0000, 1'b1, 4'h2, 1'b0, mk(3'd3, 4'b0010, 0, 0, 0), "entry_key2"};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 4'h3, 1'b0, mk(3'd3, 4'b0010, 0, 0, 0), "entry_key3"};
    vecs[4]  = '{1'b0, 4'b0000, 1'b1, 4'h4, 1'b0, mk(3'd0, 4'b0010, 1, 0, 0), "entry_disarm"};
    vecs[5]  = '{1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, mk(3'd0, 4'b0010, 0, 0, 0), "ok_pulse_end"};
    vecs[6]  = '{1'b0, 4'b0000, 1'b1, 4'h1, 1'b0, mk(3'd0, 4'b0010, 0, 0, 0), "clr_key1"};
    vecs[7]  = '{1'b0, 4'b0000, 1'b1, 4'h2, 1'b0, mk(3'd0, 4'b0010, 0, 0, 0), "clr_key2"};
    vecs[8]  = '{1'b0, 4'b0000, 1'b1, 4'h3, 1'b1, mk(3'd0, 4'b0010, 0, 0, 0), "clear_wins"};
    vecs[9]  = '{1'b0, 4'b0000, 1'b1, 4'h1, 1'b0, mk(3'd0, 4'b0010, 0, 0, 0), "after_clr1"};
    vecs[10] = '{1'b0, 4'b0000, 1'b1, 4'h2, 1'b0, mk(3'd0, 4'b0010, 0, 0, 0), "after_clr2"};
    vecs[11] = '{1'b0, 4'b0000, 1'b1, 4'h3, 1'b0, mk(3'd0, 4'b0010, 0, 0, 0), "after_clr3"};
    vecs[12] = '{1'b0, 4'b0000, 1'b1, 4'h4, 1'b0, mk(3'd0, 4'b0010, 1, 0, 0), "after_clr_ok"};
    vecs[13] = '{1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, mk(3'd0, 4'b0010, 0, 0, 0), "idle_dis"};

    reset     = 1'b0;
    arm_req   = 1'b0;
    zone_trig = 4'b0000;
    key_valid = 1'b0;
    key_digit = 4'h0;
    key_clear = 1'b0;
    #22;
    compare(dut_o, mk(3'd0, 4'b0000, 0, 0, 0), "reset_state");
    @(negedge clk);
    reset = 1'b1;

    // Arm and exit delay.
    arm_seq();

    // Table-driven: delayed zone, disarm in ENTRY, key_clear.
    for (int i = 0; i < 14; i++)
      cyc(vecs[i].arm, vecs[i].zone, vecs[i].kv, vecs[i].kd, vecs[i].kc,
          vecs[i].exp, vecs[i].tag);

    // Entry expiry into ALARM, siren expiry back to ARMED.
    arm_seq();
    cyc(1'b0, 4'b0100, 1'b0, 4'h0, 1'b0, mk(3'd3, 4'b0100, 0, 0, 0), "entry_start");
    for (int i = 0; i < 7; i++)
      cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, mk(3'd3, 4'b0100, 0, 0, 0), "entry_hold");
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, mk(3'd4, 4'b0100, 0, 0, 0), "entry_expire");
    for (int i = 0; i < 31; i++)
      cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, mk(3'd4, 4'b0100, 0, 0, 0), "alarm_hold");
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, mk(3'd2, 4'b0100, 0, 0, 0), "alarm_expire");

    // Instant zone during ENTRY, then disarm from ALARM.
    cyc(1'b0, 4'b0010, 1'b0, 4'h0, 1'b0, mk(3'd3, 4'b0110, 0, 0, 0), "entry_again");
    cyc(1'b0, 4'b0001, 1'b0, 4'h0, 1'b0, mk(3'd4, 4'b0111, 0, 0, 0), "instant_in_entry");
    enter(16'h1234, mk(3'd4, 4'b0111, 0, 0, 0), mk(3'd0, 4'b0111, 1, 0, 0), "alarm_disarm");
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, mk(3'd0, 4'b0111, 0, 0, 0), "idle_dis2");

    // Match on the same edge as an instant trigger: match wins.
    arm_seq();
    cyc(1'b0, 4'b0010, 1'b0, 4'h0, 1'b0, mk(3'd3, 4'b0010, 0, 0, 0), "entry_3");
    for (int i = 1; i <= 3; i++)
      cyc(1'b0, 4'b0000, 1'b1, 4'(i), 1'b0, mk(3'd3, 4'b0010, 0, 0, 0), "entry3_key");
    cyc(1'b0, 4'b0001, 1'b1, 4'h4, 1'b0, mk(3'd0, 4'b0011, 1, 0, 0), "match_beats_instant");
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, mk(3'd0, 4'b0011, 0, 0, 0), "idle_dis3");

    // Fail counting: a good code resets it, three consecutive bad codes lock.
    enter(16'h9999, mk(3'd0, 4'b0011, 0, 0, 0), mk(3'd0, 4'b0011, 0, 1, 0), "bad1");
    enter(16'h1234, mk(3'd0, 4'b0011, 0, 0, 0), mk(3'd0, 4'b0011, 1, 0, 0), "good_resets");
    enter(16'h9999, mk(3'd0, 4'b0011, 0, 0, 0), mk(3'd0, 4'b0011, 0, 1, 0), "bad_a");
    enter(16'h9999, mk(3'd0, 4'b0011, 0, 0, 0), mk(3'd0, 4'b0011, 0, 1, 0), "bad_b");
    enter(16'h9999, mk(3'd0, 4'b0011, 0, 0, 0), mk(3'd0, 4'b0011, 0, 1, 1), "bad_c_lock");
    for (int i = 0; i < 64; i++)
      cyc(1'b0, 4'b0000, 1'b1, 4'(i % 4 + 1), 1'b0,
          mk(3'd0, 4'b0011, 0, 0, (i < 63) ? 1'b1 : 1'b0), "lock_hold");
    enter(16'h1234, mk(3'd0, 4'b0011, 0, 0, 0), mk(3'd0, 4'b0011, 1, 0, 0), "after_lock_ok");
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, mk(3'd0, 4'b0011, 0, 0, 0), "idle_dis4");

    // Asynchronous reset in the middle of ALARM.
    arm_seq();
    cyc(1'b0, 4'b0001, 1'b0, 4'h0, 1'b0, mk(3'd4, 4'b0001, 0, 0, 0), "instant_armed");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, mk(3'd4, 4'b0001, 0, 0, 0), "alarm_pre_reset");
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    compare(dut_o, mk(3'd0, 4'b0000, 0, 0, 0), "async_reset");
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, mk(3'd0, 4'b0000, 0, 0, 0), "post_reset_idle");

    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
